arb_requester: RTL

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_requester.sv | 121 ++++++++++++
 1 files changed

// File: rtl/arb_requester.sv
// Burst requester for a fixed-priority shared bus: requests, streams cmd_len+1 beats
// while granted, aborts on grant starvation, then holds req low for HOLDOFF cycles.
module arb_requester #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int HOLDOFF = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [3:0]        cmd_len,
  output logic              cmd_ready,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [3:0] HOLD_INIT   = 4'(HOLDOFF - 1);

  state_t              state_q;
  logic [4:0]          remaining_q;
  logic [7:0]          wait_q;
  logic [3:0]          hold_q;
  logic                req_q;
  logic                bus_valid_q;
  logic [DATA_W-1:0]   bus_data_q;
  logic                done_q;
  logic                timeout_q;

  logic                beat;
  logic [7:0]          wait_d;

  assign cmd_ready = (state_q == IDLE);
  assign src_ready = (state_q == XFER) && grant && (remaining_q != 5'd0);
  assign beat      = src_valid && src_ready;
  assign wait_d    = wait_q + 8'd1;

  assign req       = req_q;
  assign bus_valid = bus_valid_q;
  assign bus_data  = bus_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign timeout   = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= 5'd0;
      wait_q      <= 8'd0;
      hold_q      <= 4'd0;
      req_q       <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      bus_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      if (beat) begin
        bus_valid_q <= 1'b1;
        bus_data_q  <= src_data;
      end
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q     <= REQ;
            req_q       <= 1'b1;
            remaining_q <= {1'b0, cmd_len} + 5'd1;
            wait_q      <= 8'd0;
          end
        end
        REQ, XFER: begin
          // A grant in the cycle the counter would expire wins over the abort.
          if (grant) begin
            wait_q <= 8'd0;
            if (state_q == REQ) begin
              state_q <= XFER;
            end else if (beat) begin
              remaining_q <= remaining_q - 5'd1;
              if (remaining_q == 5'd1) begin
                state_q <= HOLD;
                req_q   <= 1'b0;
                done_q  <= 1'b1;
                hold_q  <= HOLD_INIT;
              end
            end
          end else if (wait_d == TIMEOUT_CNT) begin
            state_q     <= HOLD;
            req_q       <= 1'b0;
            timeout_q   <= 1'b1;
            remaining_q <= 5'd0;
            wait_q      <= 8'd0;
            hold_q      <= HOLD_INIT;
          end else begin
            wait_q <= wait_d;
          end
        end
        HOLD: begin
          if (hold_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
